// File: rtl/xilinx_reset_sequencer_pkg.sv
// rtl/xilinx_reset_sequencer_pkg.sv - shared state encoding and default timing for the reset sequencer
package xilinx_reset_sequencer_pkg;

  localparam int STATE_W             = 2;
  localparam int DEF_HOLD_CYCLES     = 64;
  localparam int DEF_GAP_CYCLES      = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 100000;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_JTAG      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xilinx_reset_debounce.sv
// rtl/xilinx_reset_debounce.sv - two-flop synchroniser followed by a level debouncer
module xilinx_reset_debounce
  import xilinx_reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic ref_clk,
  input  logic pad_reset,
  input  logic async_i,
  output logic stable_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], async_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any cycle where the synchronised level agrees with the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/xilinx_reset_sequencer.sv
// rtl/xilinx_reset_sequencer.sv - sequences debug and SoC reset release after clock lock
module xilinx_reset_sequencer
  import xilinx_reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic               ref_clk,
  input  logic               pad_reset,
  input  logic               clk_locked_i,
  input  logic               btn_reset_i,
  input  logic               bootsel_i,
  output logic               jtag_trst_no,
  output logic               soc_rst_no,
  output logic               bootsel_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int               CNT_W     = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES));
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]       locked_sync_q;
  logic [1:0]       boot_sync_q;
  logic             locked_s, boot_s, btn_stable, abort;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             jtag_q, jtag_d;
  logic             soc_q, soc_d;
  logic             boot_q, boot_d;

  xilinx_reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .ref_clk  (ref_clk),
    .pad_reset(pad_reset),
    .async_i  (btn_reset_i),
    .stable_o (btn_stable)
  );

  assign locked_s = locked_sync_q[1];
  assign boot_s   = boot_sync_q[1];
  assign abort    = !locked_s || btn_stable;

  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      locked_sync_q <= '0;
      boot_sync_q   <= '0;
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      jtag_q        <= 1'b0;
      soc_q         <= 1'b0;
      boot_q        <= 1'b0;
    end else begin
      locked_sync_q <= {locked_sync_q[0], clk_locked_i};
      boot_sync_q   <= {boot_sync_q[0], bootsel_i};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      jtag_q        <= jtag_d;
      soc_q         <= soc_d;
      boot_q        <= boot_d;
    end
  end

  // Abort is checked before counter completion so a late lock loss can never release a reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (!abort) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_JTAG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_JTAG: begin
        if (abort) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (abort) state_d = ST_WAIT_LOCK;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    jtag_d = (state_d == ST_JTAG) || (state_d == ST_RUN);
    soc_d  = (state_d == ST_RUN);
    boot_d = boot_q;
    if ((state_q == ST_WAIT_LOCK) && (state_d == ST_HOLD)) boot_d = boot_s;
  end

  assign jtag_trst_no = jtag_q;
  assign soc_rst_no   = soc_q;
  assign bootsel_o    = boot_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_xilinx_reset_sequencer.sv
// tb/tb_xilinx_reset_sequencer.sv - scoreboard bench for the reset sequencer
module tb_xilinx_reset_sequencer;

  localparam logic [1:0] S_W = 2'd0;
  localparam logic [1:0] S_H = 2'd1;
  localparam logic [1:0] S_J = 2'd2;
  localparam logic [1:0] S_R = 2'd3;

  logic       ref_clk = 1'b0;
  logic       pad_reset = 1'b1;
  logic       clk_locked_i = 1'b0;
  logic       btn_reset_i = 1'b0;
  logic       bootsel_i = 1'b0;
  logic       jtag_trst_no, soc_rst_no, bootsel_o;
  logic [1:0] state_o;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       jt;
    logic       so;
    bit         chk_bo;
    logic       bo;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  xilinx_reset_sequencer #(
    .HOLD_CYCLES    (8),
    .GAP_CYCLES     (4),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .ref_clk     (ref_clk),
    .pad_reset   (pad_reset),
    .clk_locked_i(clk_locked_i),
    .btn_reset_i (btn_reset_i),
    .bootsel_i   (bootsel_i),
    .jtag_trst_no(jtag_trst_no),
    .soc_rst_no  (soc_rst_no),
    .bootsel_o   (bootsel_o),
    .state_o     (state_o)
  );

  always #5 ref_clk = ~ref_clk;

  initial forever begin
    @(posedge ref_clk);
    cyc_cnt++;
  end

  initial forever begin
    @(negedge ref_clk);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.cyc < cyc_cnt) begin
        errors++;
        $display("FAIL %s cyc %0d: expectation not sampled, now cyc %0d", mon_e.name, mon_e.cyc, cyc_cnt);
      end else if (state_o !== mon_e.st || jtag_trst_no !== mon_e.jt || soc_rst_no !== mon_e.so ||
                   (mon_e.chk_bo && bootsel_o !== mon_e.bo)) begin
        errors++;
        $display("FAIL %s cyc %0d: got state=%0d jtag=%b soc=%b boot=%b, want state=%0d jtag=%b soc=%b boot=%b%s",
                 mon_e.name, mon_e.cyc, state_o, jtag_trst_no, soc_rst_no, bootsel_o,
                 mon_e.st, mon_e.jt, mon_e.so, mon_e.bo, mon_e.chk_bo ? "" : "(ignored)");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_until(input int n);
    while (cyc_cnt < n) begin
      @(posedge ref_clk);
      #2;
    end
  endtask

  task automatic push(input int cyc, input logic [1:0] st, input logic jt, input logic so,
                      input bit chk_bo, input logic bo, input string name);
    exp_t e;
    e.cyc = cyc; e.st = st; e.jt = jt; e.so = so; e.chk_bo = chk_bo; e.bo = bo; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    int c, k, m, p, r;

    wait_until(3);
    push(3, S_W, 0, 0, 1, 0, "reset_state");
    wait_until(4);
    pad_reset = 1'b0;
    bootsel_i = 1'b1;
    for (int n = 5; n <= 8; n++) push(n, S_W, 0, 0, 1, 0, "wait_no_lock");

    // Power-up sequence with bootsel toggled after it has been latched
    wait_until(8);
    c = cyc_cnt; k = c + 1;
    clk_locked_i = 1'b1;
    push(k + 1,  S_W, 0, 0, 1, 0, "pwr_sync_delay");
    push(k + 2,  S_H, 0, 0, 1, 1, "pwr_hold_entry");
    push(k + 9,  S_H, 0, 0, 0, 0, "pwr_hold_last");
    push(k + 10, S_J, 1, 0, 0, 0, "pwr_jtag_release");
    push(k + 13, S_J, 1, 0, 0, 0, "pwr_gap_last");
    push(k + 14, S_R, 1, 1, 1, 1, "pwr_soc_release");
    push(k + 20, S_R, 1, 1, 1, 1, "boot_held");
    wait_until(k + 4);  bootsel_i = 1'b0;
    wait_until(k + 6);  bootsel_i = 1'b1;
    wait_until(k + 16); bootsel_i = 1'b0;
    wait_until(k + 21);

    // Lock loss in RUN, then relock latches the new bootsel level
    c = cyc_cnt; m = c + 1;
    clk_locked_i = 1'b0;
    push(m + 1, S_R, 1, 1, 0, 0, "loss_sync_delay");
    push(m + 2, S_W, 0, 0, 1, 1, "loss_abort");
    wait_until(m + 5);
    c = cyc_cnt; k = c + 1;
    clk_locked_i = 1'b1;
    push(k + 2,  S_H, 0, 0, 1, 0, "relock_hold");
    push(k + 10, S_J, 1, 0, 0, 0, "relock_jtag");
    push(k + 14, S_R, 1, 1, 0, 0, "relock_run");
    wait_until(k + 16);

    // Button bouncing every 5 cycles never gets accepted
    c = cyc_cnt;
    for (int n = c + 1; n <= c + 220; n++) push(n, S_R, 1, 1, 0, 0, "bounce_ignored");
    for (int i = 0; i < 40; i++) begin
      btn_reset_i = ~btn_reset_i;
      wait_until(c + 5 * (i + 1));
    end
    wait_until(c + 221);

    // Clean 20-cycle press holds reset, release restarts the full sequence
    c = cyc_cnt; p = c + 1; r = c + 21;
    btn_reset_i = 1'b1;
    push(p + 17, S_R, 1, 1, 0, 0, "press_debouncing");
    for (int n = p + 18; n <= r + 17; n++) push(n, S_W, 0, 0, 0, 0, "press_held");
    push(r + 18, S_H, 0, 0, 0, 0, "release_hold");
    push(r + 26, S_J, 1, 0, 0, 0, "release_jtag");
    push(r + 30, S_R, 1, 1, 0, 0, "release_run");
    wait_until(c + 20);
    btn_reset_i = 1'b0;
    wait_until(r + 31);

    // Lock loss seen on the same cycle the hold counter completes
    clk_locked_i = 1'b0;
    wait_until(cyc_cnt + 4);
    c = cyc_cnt; k = c + 1;
    clk_locked_i = 1'b1;
    push(k + 9, S_H, 0, 0, 0, 0, "abort_cnt_last");
    for (int n = k + 10; n <= k + 16; n++) push(n, S_W, 0, 0, 0, 0, "abort_never_jtag");
    wait_until(k + 7);
    clk_locked_i = 1'b0;
    wait_until(k + 17);

    // Asynchronous pad_reset pulse while in JTAG
    c = cyc_cnt; k = c + 1;
    bootsel_i = 1'b1;
    clk_locked_i = 1'b1;
    push(k + 10, S_J, 1, 0, 1, 1, "pre_pulse_jtag");
    push(k + 11, S_W, 0, 0, 1, 0, "async_reset");
    push(k + 16, S_H, 0, 0, 1, 1, "restart_hold");
    push(k + 24, S_J, 1, 0, 1, 1, "restart_jtag");
    push(k + 28, S_R, 1, 1, 1, 1, "restart_run");
    wait_until(k + 11);
    pad_reset = 1'b1;
    wait_until(k + 13);
    pad_reset = 1'b0;
    wait_until(k + 30);

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s cyc %0d: expectation never reached", mon_e.name, mon_e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xilinx_reset_sequencer.md
XILINX_RESET_SEQUENCER -- requirements
Module: xilinx_reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 64, SoC/JTAG reset hold after clock lock (>=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, cycles between jtag_trst_no release and soc_rst_no release (>=1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 100000, cycles a button level must be stable before acceptance (>=2).
REQ-004 SHALL have port ref_clk  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port pad_reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clk_locked_i  in  1  MMCM/PLL lock, asynchronous to ref_clk.
REQ-007 SHALL have port btn_reset_i  in  1  board push-button, active-high, asynchronous, bouncing.
REQ-008 SHALL have port bootsel_i  in  1  board boot-select switch, asynchronous.
REQ-009 SHALL have port jtag_trst_no  out  1  debug-unit reset, active-low, to SoC pad_jtag_trst.
REQ-010 SHALL have port soc_rst_no  out  1  SoC reset, active-low, to SoC pad_reset_n.
REQ-011 SHALL have port bootsel_o  out  1  boot select latched per reset sequence, to SoC pad_bootsel.
REQ-012 SHALL have port state_o  out  2  current FSM state for debug/LED.

Function
REQ-013 SHALL synchronise clk_locked_i, btn_reset_i, bootsel_i each through 2 flops (locked_s, btn_s, boot_s).
REQ-014 SHALL debounce btn_s: counter restarts whenever btn_s equals btn_stable; when btn_s has differed for DEBOUNCE_CYCLES consecutive cycles, btn_stable takes btn_s and counter clears.
REQ-015 SHALL define abort = !locked_s || btn_stable.
REQ-016 SHALL implement FSM states WAIT_LOCK=0, HOLD=1, JTAG=2, RUN=3.
REQ-017 WAIT_LOCK: when !abort, next state HOLD, cycle counter cleared, bootsel_o <= boot_s; else remain.
REQ-018 HOLD: counter increments each cycle; at counter==HOLD_CYCLES-1 and !abort, next state JTAG, counter cleared.
REQ-019 JTAG: counter increments; at counter==GAP_CYCLES-1 and !abort, next state RUN.
REQ-020 RUN: remain until abort.
REQ-021 In HOLD, JTAG or RUN, abort SHALL force next state WAIT_LOCK, taking priority over counter completion in the same cycle.
REQ-022 Outputs SHALL be flops updated on the same edge as the state register: jtag_trst_no=1 iff state in {JTAG,RUN}; soc_rst_no=1 iff state==RUN; no combinational output paths.
REQ-023 bootsel_o SHALL change only on WAIT_LOCK->HOLD transitions; bootsel_i changes at any other time are ignored.
REQ-024 Counter width SHALL be $clog2(max(HOLD_CYCLES,GAP_CYCLES)); debounce counter width $clog2(DEBOUNCE_CYCLES); neither wraps (cleared on completion).
REQ-025 Holding the button SHALL hold the SoC in reset indefinitely; release restarts the full HOLD/JTAG sequence.

Reset
REQ-026 pad_reset high SHALL asynchronously force: state WAIT_LOCK, counters 0, btn_stable 0, synchroniser flops 0, jtag_trst_no 0, soc_rst_no 0, bootsel_o 0, state_o 0.
REQ-027 Reset deassertion mid-sequence SHALL restart from WAIT_LOCK; no state is retained.

Structure
REQ-028 State enum, state width and default parameter constants SHALL live in package xilinx_reset_sequencer_pkg.
REQ-029 Synchroniser plus debouncer SHALL be one sub-module, xilinx_reset_debounce (params DEBOUNCE_CYCLES; ports ref_clk, pad_reset, async in, stable out), instantiated for the button.

Verification (HOLD_CYCLES=8, GAP_CYCLES=4, DEBOUNCE_CYCLES=16)
REQ-030 Power-up: pad_reset released, clk_locked_i rises before edge k -> state HOLD after edge k+2, jtag_trst_no=1 after edge k+10, soc_rst_no=1 after edge k+14.
REQ-031 Lock loss in RUN: clk_locked_i low before edge m -> both resets 0 and state WAIT_LOCK after edge m+2; relock repeats REQ-030 timing.
REQ-032 Bounce: btn_reset_i toggles every 5 cycles for 200 cycles -> soc_rst_no stays 1; clean 20-cycle press -> soc_rst_no 0 within 2+16+1 cycles of press, sequence restarts after release.
REQ-033 Simultaneous abort: lock lost on the exact cycle counter==7 in HOLD -> state WAIT_LOCK, never JTAG.
REQ-034 Bootsel: bootsel_i=1 during WAIT_LOCK, toggled during HOLD/RUN -> bootsel_o=1 unchanged until next sequence.
REQ-035 Mid-sequence pad_reset pulse in JTAG state -> jtag_trst_no 0 immediately (asynchronous), full sequence restarts.
